// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate engine: STEP bit positions per clock with a start/done handshake.
// Out is only written on entry to DONE, so intermediate accumulator values never appear on it.
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [WIDTH-1:0] Out
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
    localparam logic [CNT_W:0]   W_C    = (CNT_W+1)'(WIDTH);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_rem;
    logic [2:0]       r_op;
    logic             r_err;

    logic             w_accept, w_rsvd, w_short;
    logic [CNT_W-1:0] w_s, w_rem_nxt;
    logic [CNT_W:0]   w_inv;
    logic [WIDTH-1:0] w_shifted;

    assign w_accept  = Start && (r_state != S_SHIFT);
    assign w_rsvd    = Op > 3'd4;
    assign w_short   = w_rsvd || (Cnt == '0);
    assign w_s       = (r_rem > STEP_C) ? STEP_C : r_rem;
    assign w_rem_nxt = r_rem - w_s;
    assign w_inv     = W_C - {1'b0, w_s};

    // w_s is never 0 while shifting, so w_inv stays below WIDTH for the rotates
    always_comb begin
        w_shifted = r_acc;
        case (r_op)
            3'd0:    w_shifted = r_acc << w_s;
            3'd1:    w_shifted = r_acc >> w_s;
            3'd2:    w_shifted = $signed(r_acc) >>> w_s;
            3'd3:    w_shifted = (r_acc << w_s) | (r_acc >> w_inv);
            3'd4:    w_shifted = (r_acc >> w_s) | (r_acc << w_inv);
            default: w_shifted = r_acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (Start) w_next = w_short ? S_DONE : S_SHIFT;
                else       w_next = S_IDLE;
            end
            S_SHIFT: w_next = (w_rem_nxt == '0) ? S_DONE : S_SHIFT;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == S_SHIFT);
        Done = (r_state == S_DONE);
        Err  = Done && r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_rem <= '0;
            r_op  <= '0;
            r_err <= 1'b0;
            Out   <= '0;
        end else if (w_accept) begin
            r_acc <= In;
            r_rem <= Cnt;
            r_op  <= Op;
            if (w_short) begin
                Out   <= In;
                r_err <= w_rsvd;
            end
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_shifted;
            r_rem <= w_rem_nxt;
            if (w_rem_nxt == '0) begin
                Out   <= w_shifted;
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: STEP=1 and STEP=4 instances, scoreboard of expected Done events.
module tb_iter_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st[2];
    logic [2:0]  opv[2];
    logic [15:0] inv[2];
    logic [3:0]  cntv[2];
    logic        busy_o[2], done_o[2], err_o[2];
    logic [15:0] out_o[2];

    iter_shifter #(.WIDTH(16), .CNT_W(4), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .Start(st[0]), .Op(opv[0]), .In(inv[0]), .Cnt(cntv[0]),
        .Busy(busy_o[0]), .Done(done_o[0]), .Err(err_o[0]), .Out(out_o[0]));

    iter_shifter #(.WIDTH(16), .CNT_W(4), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .Start(st[1]), .Op(opv[1]), .In(inv[1]), .Cnt(cntv[1]),
        .Busy(busy_o[1]), .Done(done_o[1]), .Err(err_o[1]), .Out(out_o[1]));

    typedef struct {
        int          sel;
        logic [15:0] out;
        logic        err;
        int          due;
        int          busy;
    } item_t;

    item_t       sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          bcnt[2];
    logic [15:0] last_out[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-level reference model for a total shift of n.
    function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] d, input int n);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 16; i++) begin
            case (op)
                3'd0: r[i] = (i >= n) ? d[i-n] : 1'b0;
                3'd1: r[i] = (i + n < 16) ? d[i+n] : 1'b0;
                3'd2: r[i] = (i + n < 16) ? d[i+n] : d[15];
                3'd3: r[i] = d[(i - n + 16) % 16];
                3'd4: r[i] = d[(i + n) % 16];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                bcnt[i]     = 0;
                last_out[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (busy_o[i] === 1'b1) bcnt[i]++;
                if (done_o[i] === 1'b1) begin
                    chk("done_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        item_t it;
                        it = sb.pop_front();
                        chk("done_inst", i, it.sel);
                        chk("out", out_o[i], it.out);
                        chk("err", err_o[i], it.err);
                        chk("latency", cyc, it.due);
                        chk("busy_cycles", bcnt[i], it.busy);
                    end
                    last_out[i] = out_o[i];
                    bcnt[i]     = 0;
                end else begin
                    chk("err_idle", err_o[i], 1'b0);
                    chk("out_hold", out_o[i], last_out[i]);
                end
            end
        end
    end

    // Called at a negedge; returns just after the sampling edge.
    task automatic go(input int sel, input logic [2:0] op, input logic [15:0] d,
                      input logic [3:0] c, input logic [15:0] exp, input int hold);
        int    step, k;
        logic  rsv;
        item_t it;
        step = (sel != 0) ? 4 : 1;
        rsv  = op > 3'd4;
        k    = (rsv || c == 4'd0) ? 0 : (int'(c) + step - 1) / step;
        st[sel] = 1'b1; opv[sel] = op; inv[sel] = d; cntv[sel] = c;
        @(posedge clk); #1;
        it.sel = sel; it.out = exp; it.err = rsv; it.due = cyc + k; it.busy = k;
        sb.push_back(it);
        if (hold > 0) begin
            inv[sel] = ~d; opv[sel] = 3'd1; cntv[sel] = 4'd3;
            repeat (hold) @(posedge clk);
            #1;
        end
        st[sel] = 1'b0;
    endtask

    // Returns at the negedge (+1) of the cycle that drained the scoreboard.
    task automatic wait_idle();
        int budget;
        budget = 200;
        do begin
            @(negedge clk); #1;
            budget--;
        end while (sb.size() != 0 && budget > 0);
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic gap();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; opv[i] = '0; inv[i] = '0; cntv[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o[0], 1'b0);
        chk("rst_done", done_o[0], 1'b0);
        chk("rst_err",  err_o[0],  1'b0);
        chk("rst_out",  out_o[0],  16'h0);
        rst = 1'b0;
        gap();

        go(0, 3'd0, 16'h8421, 4'd4, 16'h4210, 0); wait_idle(); gap();
        go(0, 3'd1, 16'h8421, 4'd4, 16'h0842, 0); wait_idle(); gap();
        go(0, 3'd2, 16'h8421, 4'd4, 16'hF842, 0); wait_idle(); gap();
        go(0, 3'd3, 16'h8421, 4'd4, 16'h4218, 0); wait_idle(); gap();
        go(0, 3'd4, 16'h8421, 4'd4, 16'h1842, 0); wait_idle(); gap();

        go(0, 3'd0, 16'hBEEF, 4'd0,  16'hBEEF, 0); wait_idle(); gap();
        go(0, 3'd2, 16'h8000, 4'd15, 16'hFFFF, 0); wait_idle(); gap();
        go(0, 3'd4, 16'h0001, 4'd15, 16'h0002, 0); wait_idle(); gap();

        go(1, 3'd1, 16'h00F0, 4'd7, 16'h0001, 0); wait_idle(); gap();

        // Start held through SHIFT with junk operands must not disturb the operation
        go(0, 3'd0, 16'h8421, 4'd4, 16'h4210, 3); wait_idle(); gap();

        // Back-to-back: second Start lands in the DONE cycle of the first
        go(0, 3'd3, 16'h1234, 4'd8, 16'h3412, 0); wait_idle();
        go(0, 3'd1, 16'hF000, 4'd3, 16'h1E00, 0); wait_idle();
        go(0, 3'd0, 16'h00FF, 4'd0, 16'h00FF, 0); wait_idle(); gap();

        go(0, 3'd6, 16'hCAFE, 4'd5, 16'hCAFE, 0); wait_idle(); gap();
        go(1, 3'd7, 16'h1357, 4'd0, 16'h1357, 0); wait_idle(); gap();

        // Reset in the middle of a shift aborts with no Done
        go(0, 3'd0, 16'h1234, 4'd9, 16'h2000, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy_o[0], 1'b0);
        chk("abort_done", done_o[0], 1'b0);
        chk("abort_out",  out_o[0],  16'h0);
        sb.delete();
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (15) @(negedge clk);
        go(0, 3'd2, 16'h8421, 4'd4, 16'hF842, 0); wait_idle(); gap();

        for (int n = 0; n < 16; n++) begin
            int          sel;
            logic [2:0]  op;
            logic [15:0] d;
            logic [3:0]  c;
            sel = int'($urandom_range(0, 1));
            op  = 3'($urandom_range(0, 7));
            d   = 16'($urandom);
            c   = 4'($urandom_range(0, 15));
            go(sel, op, d, c, model(op, d, int'(c)), 0);
            wait_idle();
            if (n % 3 == 0) gap();
        end
        gap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle, parametrised shift/rotate unit.
- Successor to the single-stage 1-bit zero-fill right shifter. Adds:
  - generic width;
  - multi-bit counts;
  - five shift/rotate modes, including arithmetic right;
  - STEP bit positions of shifting per clock;
  - a start/done handshake.
- Sits beside the ALU as the low-area shift engine. The execute stage stalls on Busy.

Parameters:
- WIDTH, 16: data width in bits; power of 2, at least 4.
- CNT_W, 4: count width; must equal log2(WIDTH).
- STEP, 1: maximum bit positions shifted per cycle; power of 2, 1 to WIDTH/2.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
- In  in  WIDTH  operand.
- Cnt  in  CNT_W  shift amount, 0 to WIDTH-1.
- Busy  out  1  high while in state SHIFT.
- Done  out  1  one-cycle pulse; Out is valid.
- Err  out  1  high with Done when Op was reserved.
- Out  out  WIDTH  result register.

Behaviour:
- Reset: asynchronous and active-high, as already decided. While rst=1:
  - state goes to IDLE immediately;
  - Busy=0, Done=0, Err=0, Out=0;
  - internal accumulator, remaining-count and op registers are cleared.
  - Reset during SHIFT aborts the operation with no Done.
- States: IDLE, SHIFT, DONE.
- IDLE and DONE (Busy=0): on Start=1, latch In into acc, Cnt into rem, and Op.
  - If Cnt=0 or Op is reserved, go to DONE.
  - Otherwise go to SHIFT.
  - With Start=0: DONE returns to IDLE and IDLE stays in IDLE.
- SHIFT: each cycle, let s = min(STEP, rem).
  - acc is shifted or rotated by s according to the latched Op; rem is decremented by s.
  - When rem becomes 0 on this edge, go to DONE.
  - Start and the In, Cnt, Op inputs are ignored while Busy=1.
- On entering DONE:
  - Out is loaded with acc; for Cnt=0 or a reserved Op, that is the unmodified In.
  - Err is loaded with 1 if the Op was reserved, else 0.
- DONE lasts exactly one cycle: Done=1 and Err is valid.
- Out holds its value until the next entry into DONE; intermediate acc values never reach Out.
- Back-to-back: Start asserted during the DONE cycle is accepted. No idle cycle is needed and Done pulses once per operation.
- Latency: with Start sampled at edge t, Done is high in the cycle after edge t + ceil(Cnt/STEP).
  - Cnt=0 gives 1 cycle.
  - Cnt=WIDTH-1 with STEP=1 gives WIDTH cycles.
- Mode semantics, for a total shift of n bits:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: replicate the original In[WIDTH-1] (sign held constant through all steps).
  - ROL / ROR: bits wrap modulo WIDTH.
  - The result is identical for every legal STEP; only latency differs.
- Cnt is unsigned. No masking is needed because Cnt is at most WIDTH-1 by width.

Test Plan:
- Reset: assert rst mid-SHIFT (WIDTH=16, STEP=1, Op=SLL, Cnt=9, after 3 cycles) -> Busy, Done, Out go to 0 immediately. No Done after rst is released; the next Start operates normally.
- Modes (WIDTH=16, STEP=1), all with In=16'h8421, Cnt=4:
  - SLL -> Out=16'h4210
  - SRL -> Out=16'h0842
  - SRA -> Out=16'hF842
  - ROL -> Out=16'h4218
  - ROR -> Out=16'h1842
  - Each Done occurs 5 cycles after the Start cycle; Busy is high for 4 cycles.
- Boundaries:
  - Cnt=0, In=16'hBEEF -> Out=16'hBEEF with Done 1 cycle later.
  - Cnt=15, SRA, In=16'h8000 -> Out=16'hFFFF.
  - Cnt=15, ROR, In=16'h0001 -> Out=16'h0002.
- STEP=4 instance: In=16'h00F0, Cnt=7, SRL -> Out=16'h0001 with Done 3 cycles after Start (4+3 shift).
- Handshake:
  - Start held high during Busy is ignored.
  - Start during the DONE cycle with new operands is accepted; two Done pulses arrive with correct Out values.
  - Reserved Op=3'b110 -> Out=In, Err=1 for exactly one cycle with Done.
